ntt_stream_driver: RTL and testbench
====================================

// Module: ntt_stream_driver
// PURPOSE
// Host-side counterpart of the streaming NTT core: buffers one 8-point frame (8 coefficients + 3x8 stage
// twiddles), serializes it into the core's four input streams while holding streaming_mode high, then drops
// streaming_mode and deserializes the core's serial result into an 8-entry result buffer drained over valid/ready.
// Sits between the system bus / test host and the combined radix core; owns all streaming_mode sequencing.
// PARAMETERS
// WIDTH    18  word width of coefficients, twiddles and results (matches core WIDTH)
// N_PTS    8   words per frame; fixed at 8 for the current core; index width 3
// OUT_LAT  1   cycles from streaming_mode falling to the first valid word on output_core_stream
// PORTS
// clock              in   1      single clock; all state updates on rising edge
// reset              in   1      synchronous, active-high
// wr_en              in   1      host write strobe into frame buffer
// wr_sel             in   2      buffer select: 0 coeff, 1 weight_1, 2 weight_2, 3 weight_3
// wr_addr            in   3      element index 0..7
// wr_data            in   WIDTH  word to store
// start              in   1      one-cycle request to run the loaded frame
// cfg_mode           in   1      NTT(0)/INTT(1); sampled on accepted start
// cfg_radix_mode     in   2      stage select forwarded to core; sampled on accepted start
// busy               out  1      high from accepted start until last result word accepted
// input_core_stream  out  WIDTH  serial coefficient stream to core
// weight_1_stream    out  WIDTH  serial stage-1 twiddle stream
// weight_2_stream    out  WIDTH  serial stage-2 twiddle stream
// weight_3_stream    out  WIDTH  serial stage-3 twiddle stream
// streaming_mode     out  1      1 = core shifts inputs in; 0 = core shifts outputs out
// mode               out  1      registered cfg_mode to core
// radix_mode         out  2      registered cfg_radix_mode to core
// output_core_stream in   WIDTH  serial result from core
// res_valid          out  1      result word available
// res_ready          in   1      host accepts result word
// res_data           out  WIDTH  result word
// res_index          out  3      index 0..7 of res_data
// done               out  1      one-cycle pulse when result word 7 is accepted
// BEHAVIOUR
// - Reset: state IDLE; busy, streaming_mode, mode, res_valid, done = 0; radix_mode = 0; all stream outputs and
//   res_data = 0; counters = 0. Frame/result buffers are NOT cleared. Reset mid-frame aborts immediately.
// - FSM IDLE -> SHIFT_IN -> DRAIN -> CAPTURE -> UNLOAD -> IDLE.
// - IDLE: wr_en writes buf[wr_sel][wr_addr] next edge. start accepted only here; latches cfg, busy=1.
// - SHIFT_IN (8 cycles, k=0..7): streaming_mode=1; all four streams drive element k of their buffers (element 0
//   first), registered outputs, so element k is on the pins exactly during shift cycle k.
// - DRAIN (OUT_LAT cycles): streaming_mode=0, streams driven 0.
// - CAPTURE (8 cycles, j=0..7): streaming_mode=0; output_core_stream sampled into result[j].
// - UNLOAD: res_valid=1, res_data=result[idx], res_index=idx; idx advances only on res_valid&&res_ready;
//   res_valid holds with stable data under backpressure; on accept of idx 7: done=1 for one cycle, busy=0, IDLE.
// - streaming_mode is 1 only in SHIFT_IN; outside it the core's input shifter is frozen.
// - start while busy ignored (no queueing). wr_en while busy ignored (frame buffer immutable during a run).
// - wr_en and start in the same IDLE cycle: write lands, start accepted; shifted frame includes the new word.
// - No arithmetic; words pass through unmodified; reduction mod q is the core's responsibility.
// - Frame-to-frame: start accepted in cycle after done; minimum frame period 8+OUT_LAT+8+8+1 cycles.
// STRUCTURE
// - Shared include ntt_defs.vh: state encodings, WR_SEL_* codes, N_PTS, index width.
// - Sub-module ntt_frame_buf: 4x8xWIDTH register file, one write port, four indexed read ports (one per
//   stream), instantiated once; result buffer is a plain 8-entry array in this module.
// TESTING
// - Reset: assert reset 2 cycles mid-SHIFT_IN -> next cycle state IDLE, streaming_mode=0, busy=0, streams 0.
// - Load coeff k=k+1, w1=0x100+k, w2=0x200+k, w3=0x300+k; start -> 8 cycles streaming_mode=1 with
//   input_core_stream 1..8 and weight streams 0x100..0x107 etc. in index order.
// - Loopback model (core output = input +0x1000 after OUT_LAT=1) -> res_data 0x1001..0x1008, res_index 0..7.
// - Backpressure: res_ready low 5 cycles at idx 3 -> res_valid stays 1, res_data/res_index unchanged; done
//   pulses exactly once, cycle of idx-7 accept.
// - start and wr_en during busy -> ignored; rerun shows original frame, single done per accepted start.
// - Same-cycle wr_en(coeff[0]=0x3FFFF)+start in IDLE -> first shifted coeff is 0x3FFFF; cfg_mode=1,
//   cfg_radix_mode=2 appear on mode/radix_mode next cycle and hold through UNLOAD.

Source files
------------

// File: rtl/ntt_stream_driver_pkg.sv
// Shared types and constants for the NTT stream driver:
// frame geometry, buffer selects and sequencer states.
package ntt_stream_driver_pkg;

    localparam int WIDTH   = 18;
    localparam int N_PTS   = 8;
    localparam int IDX_W   = 3;
    localparam int OUT_LAT = 1;
    localparam int N_BUF   = 4;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        WR_SEL_COEFF = 2'd0,
        WR_SEL_W1    = 2'd1,
        WR_SEL_W2    = 2'd2,
        WR_SEL_W3    = 2'd3
    } wr_sel_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_IN,
        S_DRAIN,
        S_CAPTURE,
        S_UNLOAD
    } state_e;

endpackage

// File: rtl/ntt_stream_driver_if.sv
// Host and core-facing signal bundle of the NTT stream driver.
// master = host/core side, slave = driver side.
interface ntt_stream_driver_if;
    import ntt_stream_driver_pkg::*;

    logic       wr_en;
    logic [1:0] wr_sel;
    idx_t       wr_addr;
    word_t      wr_data;
    logic       start;
    logic       cfg_mode;
    logic [1:0] cfg_radix_mode;
    logic       busy;
    word_t      input_core_stream;
    word_t      weight_1_stream;
    word_t      weight_2_stream;
    word_t      weight_3_stream;
    logic       streaming_mode;
    logic       mode;
    logic [1:0] radix_mode;
    word_t      output_core_stream;
    logic       res_valid;
    logic       res_ready;
    word_t      res_data;
    idx_t       res_index;
    logic       done;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data,
        output start, cfg_mode, cfg_radix_mode,
        output output_core_stream, res_ready,
        input  busy, input_core_stream,
        input  weight_1_stream, weight_2_stream, weight_3_stream,
        input  streaming_mode, mode, radix_mode,
        input  res_valid, res_data, res_index, done
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data,
        input  start, cfg_mode, cfg_radix_mode,
        input  output_core_stream, res_ready,
        output busy, input_core_stream,
        output weight_1_stream, weight_2_stream, weight_3_stream,
        output streaming_mode, mode, radix_mode,
        output res_valid, res_data, res_index, done
    );

endinterface

// File: rtl/ntt_stream_driver_frame_buf.sv
// 4x8 frame register file: one write port, one read per buffer.
// Reads see a same-cycle write to the addressed word.
module ntt_stream_driver_frame_buf
    import ntt_stream_driver_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         we_i,
    input  logic [1:0]                   sel_i,
    input  idx_t                         waddr_i,
    input  word_t                        wdata_i,
    input  idx_t                         raddr_i,
    output logic [N_BUF-1:0][WIDTH-1:0]  rdata_o
);

    word_t mem_q [N_BUF][N_PTS];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[sel_i][waddr_i] <= wdata_i;
    end

    for (genvar b = 0; b < N_BUF; b++) begin : g_rd
        logic hit;
        assign hit = we_i && (sel_i == 2'(b)) && (waddr_i == raddr_i);
        assign rdata_o[b] = hit ? wdata_i : mem_q[b][raddr_i];
    end

endmodule

// File: rtl/ntt_stream_driver.sv
// Buffers one 8-point frame, streams it into the NTT core,
// captures the serial result and drains it over valid/ready.
module ntt_stream_driver
    import ntt_stream_driver_pkg::*;
(
    input logic                 clock,
    input logic                 reset,
    ntt_stream_driver_if.slave  bus
);

    state_e state_q, state_d;
    idx_t   cnt_q, cnt_d;
    logic   sm_q, mode_q;
    logic [1:0] radix_q;
    logic [N_BUF-1:0][WIDTH-1:0] rd_data, strm_q, strm_d;
    word_t  res_q [N_PTS];
    logic   idle, accept, wr_ok, last, unload;
    idx_t   rd_idx;

    assign idle   = (state_q == S_IDLE);
    assign unload = (state_q == S_UNLOAD);
    assign accept = idle && bus.start;
    assign wr_ok  = idle && bus.wr_en;
    assign last   = (cnt_q == IDX_W'(N_PTS - 1));
    // Outputs are registered, so fetch the word for the next shift cycle.
    assign rd_idx = idle ? '0 : cnt_q + 3'd1;

    ntt_stream_driver_frame_buf u_buf (
        .clk_i   (clock),
        .we_i    (wr_ok),
        .sel_i   (bus.wr_sel),
        .waddr_i (bus.wr_addr),
        .wdata_i (bus.wr_data),
        .raddr_i (rd_idx),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SHIFT_IN;
                    cnt_d   = '0;
                end
            end
            S_SHIFT_IN: begin
                cnt_d = cnt_q + 3'd1;
                if (last) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == IDX_W'(OUT_LAT - 1)) begin
                    state_d = S_CAPTURE;
                    cnt_d   = '0;
                end
            end
            S_CAPTURE: begin
                cnt_d = cnt_q + 3'd1;
                if (last) begin
                    state_d = S_UNLOAD;
                    cnt_d   = '0;
                end
            end
            S_UNLOAD: begin
                if (bus.res_ready) begin
                    cnt_d = cnt_q + 3'd1;
                    if (last) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign strm_d = (state_d == S_SHIFT_IN) ? rd_data : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            strm_q  <= '0;
            sm_q    <= 1'b0;
            mode_q  <= 1'b0;
            radix_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            strm_q  <= strm_d;
            sm_q    <= (state_d == S_SHIFT_IN);
            if (accept) begin
                mode_q  <= bus.cfg_mode;
                radix_q <= bus.cfg_radix_mode;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && state_q == S_CAPTURE)
            res_q[cnt_q] <= bus.output_core_stream;
    end

    assign bus.busy              = !idle;
    assign bus.streaming_mode    = sm_q;
    assign bus.mode              = mode_q;
    assign bus.radix_mode        = radix_q;
    assign bus.input_core_stream = strm_q[0];
    assign bus.weight_1_stream   = strm_q[1];
    assign bus.weight_2_stream   = strm_q[2];
    assign bus.weight_3_stream   = strm_q[3];
    assign bus.res_valid         = unload;
    assign bus.res_data          = unload ? res_q[cnt_q] : '0;
    assign bus.res_index         = unload ? cnt_q : '0;
    assign bus.done              = unload && bus.res_ready && last;

endmodule

// File: tb/tb_ntt_stream_driver.sv
// Bench for ntt_stream_driver with a loopback core model
// (result = input + 0x1000, first word OUT_LAT after streaming drops).
module tb_ntt_stream_driver;
    import ntt_stream_driver_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ntt_stream_driver_if bus ();

    ntt_stream_driver dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    int vecs = 0;
    int errs = 0;
    word_t fr [4][8];

    // Loopback core: remembers the 8 words shifted in, replays them +0x1000.
    word_t cm [8];
    int    cn = 0;
    int    since = 100;
    logic  prev_sm = 1'b0;

    always @(negedge clk) begin
        if (bus.streaming_mode === 1'b1) begin
            if (!prev_sm) cn = 0;
            if (cn < 8) cm[cn] = bus.input_core_stream;
            cn++;
            since = 0;
        end else if (since < 1000) begin
            since++;
        end
        prev_sm = bus.streaming_mode;
        if (since >= 1 + OUT_LAT && since - 1 - OUT_LAT < 8)
            bus.output_core_stream = cm[since-1-OUT_LAT] + 18'h01000;
        else
            bus.output_core_stream = '0;
    end

    task automatic load_frame(input bit pattern);
        word_t w;
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (pattern)
                    w = (s == 0) ? word_t'(k + 1) : word_t'(256 * s + k);
                else
                    w = word_t'($urandom);
                bus.wr_en   = 1'b1;
                bus.wr_sel  = 2'(s);
                bus.wr_addr = 3'(k);
                bus.wr_data = w;
                fr[s][k]    = w;
            end
        end
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic run_frame(input bit cmode, input logic [1:0] rmode,
                             input bit wr0, input word_t w0, input bit poke,
                             input int bp_idx, input int bp_len, input bit rnd);
        word_t exp_r [8];
        int idx, stall, dn, guard;
        bit rdy;
        logic [4*WIDTH-1:0] es, as;
        @(negedge clk);
        bus.res_ready = 1'b0;
        vecs++;
        if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
            errs++;
            $display("FAIL idle_before_start busy=%b valid=%b need 0 0",
                     bus.busy, bus.res_valid);
        end
        bus.start          = 1'b1;
        bus.cfg_mode       = cmode;
        bus.cfg_radix_mode = rmode;
        if (wr0) begin
            bus.wr_en   = 1'b1;
            bus.wr_sel  = 2'd0;
            bus.wr_addr = 3'd0;
            bus.wr_data = w0;
            fr[0][0]    = w0;
        end
        for (int j = 0; j < 8; j++) exp_r[j] = fr[0][j] + 18'h01000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.cfg_mode       = ~cmode;
            bus.cfg_radix_mode = ~rmode;
            bus.start = poke && k == 2;
            bus.wr_en = poke && k == 2;
            bus.wr_sel  = 2'($urandom);
            bus.wr_addr = 3'($urandom);
            bus.wr_data = word_t'($urandom);
            es = {fr[0][k], fr[1][k], fr[2][k], fr[3][k]};
            as = {bus.input_core_stream, bus.weight_1_stream,
                  bus.weight_2_stream, bus.weight_3_stream};
            vecs++;
            if (as !== es) begin
                errs++;
                $display("FAIL shift_streams k=%0d got %h need %h", k, as, es);
            end
            vecs++;
            if ({bus.streaming_mode, bus.busy, bus.mode, bus.radix_mode}
                !== {1'b1, 1'b1, cmode, rmode}) begin
                errs++;
                $display("FAIL shift_ctrl k=%0d sm/busy/mode/radix=%b%b%b%b need 11%b%b",
                         k, bus.streaming_mode, bus.busy, bus.mode,
                         bus.radix_mode, cmode, rmode);
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        as = {bus.input_core_stream, bus.weight_1_stream,
              bus.weight_2_stream, bus.weight_3_stream};
        vecs++;
        if (bus.streaming_mode !== 1'b0 || as !== '0) begin
            errs++;
            $display("FAIL drain sm=%b streams=%h need 0 0", bus.streaming_mode, as);
        end
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            vecs++;
            if ({bus.streaming_mode, bus.res_valid, bus.busy} !== 3'b001) begin
                errs++;
                $display("FAIL capture j=%0d sm/valid/busy=%b%b%b need 001",
                         j, bus.streaming_mode, bus.res_valid, bus.busy);
            end
        end
        idx = 0; stall = 0; dn = 0; guard = 0;
        while (idx < 8 && guard < 200) begin
            @(negedge clk);
            guard++;
            vecs++;
            if ({bus.res_valid, bus.res_data, bus.res_index}
                !== {1'b1, exp_r[idx], 3'(idx)}) begin
                errs++;
                $display("FAIL unload valid/data/idx=%b/%h/%0d need 1/%h/%0d",
                         bus.res_valid, bus.res_data, bus.res_index,
                         exp_r[idx], idx);
            end
            vecs++;
            if ({bus.mode, bus.radix_mode, bus.busy} !== {cmode, rmode, 1'b1}) begin
                errs++;
                $display("FAIL unload_cfg mode/radix/busy=%b/%0d/%b need %b/%0d/1",
                         bus.mode, bus.radix_mode, bus.busy, cmode, rmode);
            end
            rdy = 1'b1;
            if (idx == bp_idx && stall < bp_len) begin
                rdy = 1'b0;
                stall++;
            end else if (rnd) begin
                rdy = 1'($urandom_range(0, 1));
            end
            bus.start     = poke && idx == 3;
            bus.res_ready = rdy;
            #1;
            vecs++;
            if (bus.done !== (rdy && idx == 7)) begin
                errs++;
                $display("FAIL done idx=%0d got %b need %b", idx, bus.done,
                         rdy && idx == 7);
            end
            if (bus.done === 1'b1) dn++;
            if (rdy) idx++;
        end
        vecs++;
        if (idx != 8 || dn != 1) begin
            errs++;
            $display("FAIL unload_end idx=%0d dones=%0d need 8 1", idx, dn);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vecs++;
        if ({bus.busy, bus.streaming_mode, bus.mode, bus.radix_mode,
             bus.res_valid, bus.done, bus.res_data} !== '0) begin
            errs++;
            $display("FAIL reset_ctrl busy/sm/mode/radix/valid/done/data=%b%b%b%b%b%b/%h need 0",
                     bus.busy, bus.streaming_mode, bus.mode, bus.radix_mode,
                     bus.res_valid, bus.done, bus.res_data);
        end
        vecs++;
        if ({bus.input_core_stream, bus.weight_1_stream,
             bus.weight_2_stream, bus.weight_3_stream} !== '0) begin
            errs++;
            $display("FAIL reset_streams got nonzero %h need 0",
                     bus.input_core_stream);
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        @(negedge clk);
        bus.start = 1'b1; bus.cfg_mode = 1'b1; bus.cfg_radix_mode = 2'd3;
        @(negedge clk);
        bus.start = 1'b0;
        vecs++;
        if (bus.streaming_mode !== 1'b1) begin
            errs++;
            $display("FAIL midreset_pre sm=%b need 1", bus.streaming_mode);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vecs++;
        if ({bus.streaming_mode, bus.busy, bus.mode, bus.radix_mode,
             bus.input_core_stream, bus.weight_1_stream,
             bus.weight_2_stream, bus.weight_3_stream} !== '0) begin
            errs++;
            $display("FAIL midreset sm/busy/mode=%b%b%b in=%h need 0",
                     bus.streaming_mode, bus.busy, bus.mode, bus.input_core_stream);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_pattern();
        load_frame(1'b1);
        run_frame(1'b0, 2'd0, 1'b0, '0, 1'b0, -1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_frame(1'b0, 2'd1, 1'b0, '0, 1'b0, 3, 5, 1'b0);
    endtask

    task automatic test_busy_ignored();
        run_frame(1'b1, 2'd3, 1'b0, '0, 1'b1, -1, 0, 1'b0);
        run_frame(1'b0, 2'd0, 1'b0, '0, 1'b0, -1, 0, 1'b0);
    endtask

    task automatic test_same_cycle();
        run_frame(1'b1, 2'd2, 1'b1, 18'h3FFFF, 1'b0, -1, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_frame(1'b0, 2'd1, 1'b0, '0, 1'b0, -1, 0, 1'b0);
        run_frame(1'b1, 2'd0, 1'b0, '0, 1'b0, -1, 0, 1'b0);
    endtask

    task automatic test_random();
        repeat (4) begin
            load_frame(1'b0);
            run_frame(1'($urandom), 2'($urandom), 1'($urandom),
                      word_t'($urandom), 1'($urandom),
                      $urandom_range(0, 7), $urandom_range(0, 3), 1'b1);
        end
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_sel = '0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.start = 1'b0; bus.cfg_mode = 1'b0; bus.cfg_radix_mode = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_pattern();
        test_backpressure();
        test_busy_ignored();
        test_same_cycle();
        test_reset_mid_shift();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
